// File: rtl/seq_adder_n.sv
// seq_adder_n: multi-cycle WIDTH-bit adder that adds DIGIT bits per clock,
// least significant digit first, with a registered carry between digits.
//
// Optional feature macro: SEQ_ADDER_SUB_EN
//   When defined, an extra input 'sub' is captured with the operands; sub=1
//   computes a + ~b + 1 (cin ignored), so cout=1 means no borrow.
//   When undefined, the block is a pure adder with no 'sub' port.
//
// Handshake: start is sampled only while idle; an accepted start captures
// a/b/cin, busy is high for NDIG cycles, then done pulses for one cycle in the
// same cycle that sum/cout take the new result (busy is already low then).
// Starts while busy are ignored; sum/cout hold until the next done or reset.
module seq_adder_n #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reject illegal parameter combinations at elaboration time.
  if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("seq_adder_n: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] part_r;
  logic             carry_r;
`ifdef SEQ_ADDER_SUB_EN
  logic             sub_r;
`endif

  logic                   last;
  logic [DIGIT-1:0]       b_dig;
  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       part_nx;

  // The digit being processed is the last one of the operation.
  assign last = (cnt == CW'(NDIG - 1));

  // busy is a pure decode of the state register.
  assign busy = (state == RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: idle until start, run until the last digit is added.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One digit of addition; the new digit enters the partial word at the MSB end.
  always_comb begin
    b_dig = b_sh[DIGIT-1:0];
`ifdef SEQ_ADDER_SUB_EN
    b_dig = b_sh[DIGIT-1:0] ^ {DIGIT{sub_r}};
`endif
    dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_r};
    cat     = {dsum[DIGIT-1:0], part_r} >> DIGIT;
    part_nx = cat[WIDTH-1:0];
  end

  // Operand capture, digit stepping, and result/done update on the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      part_r  <= '0;
      carry_r <= 1'b0;
`ifdef SEQ_ADDER_SUB_EN
      sub_r   <= 1'b0;
`endif
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            a_sh   <= a;
            b_sh   <= b;
            part_r <= '0;
`ifdef SEQ_ADDER_SUB_EN
            sub_r   <= sub;
            carry_r <= sub ? 1'b1 : cin;
`else
            carry_r <= cin;
`endif
          end
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          part_r  <= part_nx;
          carry_r <= dsum[DIGIT];
          cnt     <= cnt + CW'(1);
          if (last) begin
            sum  <= part_nx;
            cout <= dsum[DIGIT];
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_adder_n.md
Name: seq_adder_n

Overview:
- Parametrised multi-cycle adder, successor to the team's single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first, with a registered carry chaining between digits.
- Start/busy/done handshake; result registers hold the last result.
- Sits beside datapath blocks where a wide single-cycle adder is too costly in area.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be >= 1.
- DIGIT, 4, bits added per clock; 1 <= DIGIT <= WIDTH, and WIDTH % DIGIT == 0.
- NDIG, WIDTH/DIGIT, derived (localparam): number of digit cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when sum/cout are updated.
- sum  out  WIDTH  registered result; holds its value until the next done.
- cout  out  1  registered carry-out of the MSB digit.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0; digit counter=0; internal operand/carry/partial registers=0.
- States:
  - IDLE -> RUN on start=1; captures a, b, cin, counter=0.
  - RUN -> RUN while counter < NDIG-1.
  - RUN -> IDLE on the edge processing digit NDIG-1.
- RUN digit step, per clock:
  - DIGIT+1-bit add of a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry_r.
  - Low DIGIT bits go into the partial register from the MSB end (shift right by DIGIT).
  - The top bit updates carry_r.
  - a_sh and b_sh shift right by DIGIT; counter increments.
- Completion edge (last digit):
  - sum <= final partial word; cout <= final carry.
  - done=1 for exactly one cycle; busy=0 in that same cycle.
- Latency: start sampled at edge k -> busy=1 from edge k through k+NDIG-1 -> done=1 and result valid after edge k+NDIG. For the defaults, NDIG=4.
- DIGIT==WIDTH: NDIG=1; done one cycle after start.
- busy is registered and driven from state (busy = state==RUN); done is registered.
- start while busy: ignored; operands are not re-captured.
- start in the cycle done=1 (state already IDLE): accepted; back-to-back throughput is one result per NDIG+1 cycles.
- a/b/cin changing after capture: no effect on the operation in flight.
- Wrap-around: the sum is modulo 2^WIDTH; the carry out of the top bit appears only on cout.
- Reset mid-operation: immediate abort; no done pulse; sum/cout cleared to 0.
- Outputs sum/cout never show partial values; they change only on completion edges or reset.

Optional Feature:
- Macro: SEQ_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands on start.
  - sub=1: computes a + ~b + 1. The initial carry_r is forced to 1 and cin is ignored. Each digit of b is inverted before the add. cout=1 means no borrow (a >= b unsigned).
  - sub=0: identical to the base behaviour.
- Undefined: no sub port; addition only; area and timing identical to the base design.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- Reset, then start with a=0x1234, b=0x4321, cin=0 -> busy high 4 cycles; done pulse after edge k+4; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Verifies the carry ripple across all digits.
- Start held high continuously with changing operands -> one result per 5 cycles. Starts while busy are ignored, and the result matches only the operands captured at acceptance.
- Assert rst at the 2nd RUN cycle of a=0x00FF, b=0x0001 -> done never pulses, sum=0, cout=0, busy=0 immediately. A new start afterwards gives the correct 0x0100.
- Parameter sweep DIGIT in {1, 4, 16}, 200 random operand/cin sets each -> {cout,sum} == a+b+cin, done exactly NDIG cycles after start (16/4/1).
- With SEQ_ADDER_SUB_EN, sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
